// File: rtl/svo_tmds_dec_if.sv
// Interface for one TMDS receive channel. It carries the raw deserializer
// word toward the decoder, and the decoded fields plus the alignment status back.
interface svo_tmds_dec_if;
    logic [9:0] din;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] dout;
    logic       locked;
    logic       bitslip;
    logic [3:0] slip_cnt;

    // Deserializer side: supplies words and reacts to bitslip.
    modport master (
        output din,
        input  de, ctrl, dout, locked, bitslip, slip_cnt
    );

    // Decoder side.
    modport slave (
        input  din,
        output de, ctrl, dout, locked, bitslip, slip_cnt
    );
endinterface

// File: rtl/svo_tmds_dec.sv
// Single-channel TMDS receive decoder. It finds word alignment from control-token
// runs, requests a bitslip while unaligned, and decodes aligned words to de/ctrl/pixel data.
module svo_tmds_dec #(
    parameter int CTRL_RUN    = 8,
    parameter int TIMEOUT     = 4096,
    parameter int SLIP_SETTLE = 16
) (
    input  logic          clk,
    input  logic          resetn,
    svo_tmds_dec_if.slave bus
);

    localparam int TIMER_W  = (TIMEOUT     < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int RUN_W    = (CTRL_RUN    < 1) ? 1 : $clog2(CTRL_RUN + 1);
    localparam int SETTLE_W = (SLIP_SETTLE < 1) ? 1 : $clog2(SLIP_SETTLE + 1);

    localparam logic [TIMER_W-1:0]  TIMER_LIMIT  = TIMER_W'(TIMEOUT);
    localparam logic [RUN_W-1:0]    RUN_LIMIT    = RUN_W'(CTRL_RUN);
    localparam logic [SETTLE_W-1:0] SETTLE_LIMIT = SETTLE_W'(SLIP_SETTLE);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_SETTLE = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    function automatic logic is_ctrl_token(input logic [9:0] w);
        logic hit;
        case (w)
            10'b1101010100,
            10'b0010101011,
            10'b0101010100,
            10'b1010101011: hit = 1'b1;
            default:        hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic [1:0] ctrl_token_val(input logic [9:0] w);
        logic [1:0] c;
        case (w)
            10'b1101010100: c = 2'b00;
            10'b0010101011: c = 2'b01;
            10'b0101010100: c = 2'b10;
            10'b1010101011: c = 2'b11;
            default:        c = 2'b00;
        endcase
        return c;
    endfunction

    // Undo the optional inversion (bit 9), then the XOR/XNOR chain (bit 8 selects XOR).
    function automatic logic [7:0] tmds_decode_data(input logic [9:0] w);
        logic [7:0] q;
        logic [7:0] d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return d;
    endfunction

    logic [9:0]          din_r;
    logic                is_ctrl_r;
    logic                de_r;
    logic [1:0]          ctrl_r;
    logic [7:0]          dout_r;

    state_t              state_r,  state_next;
    logic [TIMER_W-1:0]  timer_r,  timer_next,  timer_inc_s;
    logic [RUN_W-1:0]    run_r,    run_next,    run_inc_s;
    logic [SETTLE_W-1:0] settle_r, settle_next;

    logic                bitslip_r, bitslip_s;
    logic                locked_r,  locked_s;
    logic [3:0]          slip_cnt_r, slip_cnt_s;

    // Stage 1: capture the raw word and whether it is a control token.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            din_r     <= 10'd0;
            is_ctrl_r <= 1'b0;
        end else begin
            din_r     <= bus.din;
            is_ctrl_r <= is_ctrl_token(bus.din);
        end
    end

    // Stage 2: decoded outputs, blanked whenever the aligner is not locked.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            de_r   <= 1'b0;
            ctrl_r <= 2'b00;
            dout_r <= 8'd0;
        end else if (state_r != S_LOCKED) begin
            de_r   <= 1'b0;
            ctrl_r <= 2'b00;
            dout_r <= 8'd0;
        end else if (is_ctrl_r) begin
            de_r   <= 1'b0;
            ctrl_r <= ctrl_token_val(din_r);
        end else begin
            de_r   <= 1'b1;
            dout_r <= tmds_decode_data(din_r);
        end
    end

    // Alignment FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r  <= S_SEARCH;
            timer_r  <= '0;
            run_r    <= '0;
            settle_r <= '0;
        end else begin
            state_r  <= state_next;
            timer_r  <= timer_next;
            run_r    <= run_next;
            settle_r <= settle_next;
        end
    end

    // Both counters saturate so a stalled stream can never wrap them into a false match.
    always_comb begin
        timer_inc_s = (timer_r == TIMER_LIMIT) ? timer_r : timer_r + TIMER_W'(1);
        run_inc_s   = (run_r   == RUN_LIMIT)   ? run_r   : run_r   + RUN_W'(1);
    end

    // Alignment FSM next-state logic. A token always beats a simultaneous timer expiry.
    always_comb begin
        state_next  = state_r;
        timer_next  = timer_r;
        run_next    = run_r;
        settle_next = settle_r;
        case (state_r)
            S_SEARCH: begin
                if (is_ctrl_r) begin
                    timer_next = '0;
                    run_next   = run_inc_s;
                    if (run_inc_s == RUN_LIMIT) begin
                        state_next = S_LOCKED;
                    end else begin
                        state_next = S_SEARCH;
                    end
                end else if (timer_inc_s == TIMER_LIMIT) begin
                    run_next    = '0;
                    timer_next  = '0;
                    settle_next = '0;
                    state_next  = S_SETTLE;
                end else begin
                    run_next   = '0;
                    timer_next = timer_inc_s;
                    state_next = S_SEARCH;
                end
            end
            S_SETTLE: begin
                // The bitslip cycle itself is the first SETTLE cycle, then SLIP_SETTLE more.
                if (settle_r == SETTLE_LIMIT) begin
                    settle_next = '0;
                    run_next    = '0;
                    timer_next  = '0;
                    state_next  = S_SEARCH;
                end else begin
                    settle_next = settle_r + SETTLE_W'(1);
                    state_next  = S_SETTLE;
                end
            end
            S_LOCKED: begin
                if (is_ctrl_r) begin
                    timer_next = '0;
                    state_next = S_LOCKED;
                end else if (timer_inc_s == TIMER_LIMIT) begin
                    timer_next = '0;
                    run_next   = '0;
                    state_next = S_SEARCH;
                end else begin
                    timer_next = timer_inc_s;
                    state_next = S_LOCKED;
                end
            end
            default: begin
                state_next  = S_SEARCH;
                timer_next  = '0;
                run_next    = '0;
                settle_next = '0;
            end
        endcase
    end

    // Alignment FSM outputs, computed from the transition being taken.
    always_comb begin
        bitslip_s  = (state_r == S_SEARCH) && (state_next == S_SETTLE);
        locked_s   = (state_next == S_LOCKED);
        slip_cnt_s = slip_cnt_r;
        if (bitslip_s) begin
            slip_cnt_s = (slip_cnt_r == 4'd9) ? 4'd0 : slip_cnt_r + 4'd1;
        end else begin
            slip_cnt_s = slip_cnt_r;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            bitslip_r  <= 1'b0;
            locked_r   <= 1'b0;
            slip_cnt_r <= 4'd0;
        end else begin
            bitslip_r  <= bitslip_s;
            locked_r   <= locked_s;
            slip_cnt_r <= slip_cnt_s;
        end
    end

    assign bus.de       = de_r;
    assign bus.ctrl     = ctrl_r;
    assign bus.dout     = dout_r;
    assign bus.locked   = locked_r;
    assign bus.bitslip  = bitslip_r;
    assign bus.slip_cnt = slip_cnt_r;

endmodule

// File: tb/tb_svo_tmds_dec.sv
// Self-checking bench for svo_tmds_dec: directed words with hand-computed decode results
// go through a scoreboard; alignment, bitslip and reset behaviour are checked inline.
module tb_svo_tmds_dec;
    localparam int CTRL_RUN    = 8;
    localparam int TIMEOUT     = 4096;
    localparam int SLIP_SETTLE = 16;
    localparam int SLIP_GAP    = TIMEOUT + SLIP_SETTLE + 1;

    localparam logic [9:0] T00 = 10'b1101010100;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    svo_tmds_dec_if bus ();

    svo_tmds_dec #(
        .CTRL_RUN   (CTRL_RUN),
        .TIMEOUT    (TIMEOUT),
        .SLIP_SETTLE(SLIP_SETTLE)
    ) u_dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] dout;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Drive one word just after a rising edge; optionally queue its expected decode.
    task automatic drive(input logic [9:0] w, input bit chk, input logic e_de,
                         input logic [1:0] e_ctrl, input logic [7:0] e_dout);
        @(posedge clk);
        #1;
        bus.din = w;
        if (chk) sb_q.push_back('{cyc, e_de, e_ctrl, e_dout});
    endtask

    // Word seen by a deserializer whose alignment is off by 'off' bits on a repeating token.
    function automatic logic [9:0] rot(input logic [9:0] w, input int off);
        logic [19:0] d;
        d = {w, w};
        return d[off +: 10];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        resetn  = 1'b0;
        bus.din = 10'd0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Monitor: a word driven in cycle c shows up on the outputs two cycles later.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            if (sb_q[0].cyc + 2 == cyc) begin
                mon_e = sb_q.pop_front();
                check("sb_de",   bus.de,   mon_e.de);
                check("sb_ctrl", bus.ctrl, mon_e.ctrl);
                check("sb_dout", bus.dout, mon_e.dout);
            end else if (sb_q[0].cyc + 2 < cyc) begin
                mon_e = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL sb_missed: entry from cycle %0d never compared, now %0d", mon_e.cyc, cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded its time limit at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    logic [9:0] t2_w    [10] = '{10'h100, 10'h200, 10'h0AB, 10'h101, 10'h154,
                                 10'h055, 10'h2AB, 10'h355, 10'h10F, 10'h354};
    logic       t2_de   [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [1:0] t2_ctrl [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    logic [7:0] t2_dout [10] = '{8'h00, 8'hFF, 8'hFF, 8'h03, 8'h03, 8'h01, 8'h01, 8'hFE, 8'h11, 8'h11};

    initial begin
        int  slips;
        int  last_slip;
        int  off;
        int  n;
        bit  done;

        bus.din = 10'd0;

        // 1: reset values, then lock on an aligned token run.
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_de",       bus.de,       1'b0);
        check("rst_ctrl",     bus.ctrl,     2'd0);
        check("rst_dout",     bus.dout,     8'd0);
        check("rst_locked",   bus.locked,   1'b0);
        check("rst_bitslip",  bus.bitslip,  1'b0);
        check("rst_slip_cnt", bus.slip_cnt, 4'd0);
        resetn = 1'b1;
        for (int i = 0; i < CTRL_RUN; i++) begin
            drive(T00, 1'b1, 1'b0, 2'd0, 8'd0);
            @(negedge clk);
            check("t1_no_slip", bus.bitslip, 1'b0);
        end
        drive(T00, 1'b1, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        check("t1_lock_not_early", bus.locked, 1'b0);
        drive(T00, 1'b1, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        check("t1_locked", bus.locked, 1'b1);

        // 2: data and control decode while locked.
        for (int i = 0; i < 10; i++) begin
            drive(t2_w[i], 1'b1, t2_de[i], t2_ctrl[i], t2_dout[i]);
        end
        @(negedge clk);
        check("t2_still_locked", bus.locked, 1'b1);

        // 4: a token on the last allowed cycle keeps lock; a full timeout of data drops it.
        for (int i = 0; i < TIMEOUT - 1; i++) drive(10'h100, 1'b0, 1'b0, 2'd0, 8'd0);
        drive(T00, 1'b0, 1'b0, 2'd0, 8'd0);
        for (int i = 0; i < TIMEOUT; i++) begin
            drive(10'h100, (i == TIMEOUT - 1), 1'b1, 2'd0, 8'h00);
            if (i == 1) begin
                @(negedge clk);
                check("t4_token_keeps_lock", bus.locked, 1'b1);
            end
        end
        drive(10'h200, 1'b1, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        check("t4_locked_until_timeout", bus.locked, 1'b1);
        drive(10'h200, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        check("t4_lock_lost", bus.locked, 1'b0);
        check("t4_no_slip_on_loss", bus.bitslip, 1'b0);

        // 5: a data word inside the run restarts the count.
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            drive((i == 7) ? 10'h100 : T00, 1'b0, 1'b0, 2'd0, 8'd0);
            @(negedge clk);
            check("t5_no_lock", bus.locked, 1'b0);
        end
        drive(T00, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        drive(T00, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        check("t5_run7_no_lock", bus.locked, 1'b0);
        drive(T00, 1'b0, 1'b0, 2'd0, 8'd0);
        @(negedge clk);
        check("t5_run8_lock", bus.locked, 1'b1);

        // 3: misaligned stream needs three slips to reach alignment.
        apply_reset();
        off       = 7;
        slips     = 0;
        last_slip = 0;
        done      = 1'b0;
        for (int k = 0; k < 3 * SLIP_GAP + 200 && !done; k++) begin
            drive(rot(T00, off), 1'b0, 1'b0, 2'd0, 8'd0);
            @(negedge clk);
            if (bus.bitslip) begin
                slips++;
                if (slips > 1) check("t3_slip_spacing", cyc - last_slip, SLIP_GAP);
                last_slip = cyc;
                off = (off + 1) % 10;
            end
            if (bus.locked) done = 1'b1;
        end
        check("t3_slip_count", slips, 3);
        check("t3_slip_cnt",   bus.slip_cnt, 4'd3);
        check("t3_locked",     bus.locked, 1'b1);

        // 6a: reset on the bitslip cycle.
        apply_reset();
        bus.din = 10'h100;
        n = 0;
        while (bus.bitslip !== 1'b1 && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check("t6a_slip_seen", bus.bitslip, 1'b1);
        check("t6a_slip_cnt",  bus.slip_cnt, 4'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("t6a_bitslip",  bus.bitslip,  1'b0);
        check("t6a_slip_cnt0", bus.slip_cnt, 4'd0);
        check("t6a_locked",   bus.locked,   1'b0);
        check("t6a_de",       bus.de,       1'b0);
        check("t6a_dout",     bus.dout,     8'd0);
        resetn = 1'b1;

        // 6b: reset in the middle of SETTLE.
        n = 0;
        while (bus.bitslip !== 1'b1 && n < TIMEOUT + 50) begin
            @(negedge clk);
            n++;
        end
        check("t6b_slip_seen", bus.bitslip, 1'b1);
        repeat (5) @(negedge clk);
        check("t6b_settle_quiet", bus.bitslip, 1'b0);
        check("t6b_slip_cnt",     bus.slip_cnt, 4'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("t6b_bitslip",   bus.bitslip,  1'b0);
        check("t6b_slip_cnt0", bus.slip_cnt, 4'd0);
        check("t6b_locked",    bus.locked,   1'b0);
        check("t6b_de",        bus.de,       1'b0);
        check("t6b_dout",      bus.dout,     8'd0);
        resetn = 1'b1;

        repeat (4) @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
